// File: rtl/core_pkg.sv
// Shared types and constants for the core's EX-stage branch redirect logic.
// No logic; states and the exception cause code used by core_branch_redirect.
package core_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REDIRECT,
      EXC
   } br_redir_state_e;

   localparam logic [3:0] EXC_INSTR_ADDR_MISALIGNED = 4'd0;

endpackage

// File: rtl/core_perf_counter.sv
// Free-running event counter: +1 per cycle with i_inc high, wraps silently.
// Count visible the cycle after the increment; never stalls.
module core_perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_count <= '0;
      end else if (i_inc) begin
         o_count <= o_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/core_branch_redirect.sv
// EX-stage branch resolution vs prediction: registered redirect or misaligned-target exception,
// visible one cycle after accept; EX is held (o_br_ready=0) until fetch/trap completes the handshake.
module core_branch_redirect
   import core_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_br_valid,
   output logic             o_br_ready,
   input  logic             i_br_istaken,
   input  logic             i_br_addr_mismatch,
   input  logic             i_br_pred_taken,
   input  logic [XLEN-1:0]  i_br_pc,
   input  logic [XLEN-1:0]  i_br_target_pc,
   input  logic             i_br_is_compressed,
   input  logic             i_flush_ext,
   output logic             o_redirect_valid,
   input  logic             i_redirect_ready,
   output logic [XLEN-1:0]  o_redirect_pc,
   output logic             o_flush_ifid,
   output logic             o_exc_valid,
   input  logic             i_exc_ack,
   output logic [3:0]       o_exc_cause,
   output logic [XLEN-1:0]  o_exc_tval,
   output logic [CNT_W-1:0] o_cnt_branches,
   output logic [CNT_W-1:0] o_cnt_mispredicts
);

   br_redir_state_e state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] tval_q, tval_d;

   logic            accept;
   logic            live_accept;
   logic            mispredict;
   logic            go_exc;
   logic            go_redirect;
   logic [XLEN-1:0] seq_pc;

   assign o_br_ready  = (state_q == IDLE);
   assign accept      = i_br_valid && o_br_ready;
   // An older flush kills the resolution outright, including its branch count.
   assign live_accept = accept && !i_flush_ext;
   assign mispredict  = (i_br_istaken != i_br_pred_taken);
   assign go_exc      = live_accept && i_br_addr_mismatch;
   assign go_redirect = live_accept && !i_br_addr_mismatch && mispredict;
   assign seq_pc      = i_br_pc + (i_br_is_compressed ? XLEN'(2) : XLEN'(4));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tval_d  = tval_q;
      case (state_q)
         IDLE: begin
            if (go_exc) begin
               state_d = EXC;
               tval_d  = i_br_target_pc;
            end else if (go_redirect) begin
               state_d = REDIRECT;
               pc_d    = i_br_istaken ? i_br_target_pc : seq_pc;
            end
         end
         REDIRECT: begin
            if (i_flush_ext || i_redirect_ready) begin
               state_d = IDLE;
            end
         end
         EXC: begin
            if (i_flush_ext || i_exc_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         tval_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tval_q  <= tval_d;
      end
   end

   assign o_redirect_valid = (state_q == REDIRECT);
   assign o_redirect_pc    = pc_q;
   // A same-cycle older flush supersedes the redirect, so fetch must not also flush IF/ID.
   assign o_flush_ifid     = o_redirect_valid && i_redirect_ready && !i_flush_ext;
   assign o_exc_valid      = (state_q == EXC);
   assign o_exc_cause      = EXC_INSTR_ADDR_MISALIGNED;
   assign o_exc_tval       = tval_q;

   core_perf_counter #(.CNT_W(CNT_W)) u_cnt_branches (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (live_accept),
      .o_count (o_cnt_branches)
   );

   core_perf_counter #(.CNT_W(CNT_W)) u_cnt_mispredicts (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (go_redirect),
      .o_count (o_cnt_mispredicts)
   );

endmodule
